// File: rtl/demux1to7_collector.sv
//------------------------------------------------------------------------------
// demux1to7_collector
//
// Purpose:
//   Serial-to-parallel collector. One data bit is accepted per InValid/InReady
//   handshake and steered into one of 7 lanes. The lane comes either from an
//   internal auto-incrementing pointer (AddrMode=0) or from DemuxSelect
//   (AddrMode=1). When every lane of the current word has been written, the
//   word is presented on OutWord with OutValid and held until OutReady.
//
// Ports:
//   Clock        in   system clock, rising edge active
//   Resetn       in   asynchronous active-low reset
//   DataIn       in   serial data bit
//   InValid      in   DataIn valid this cycle
//   InReady      out  collector can accept a bit (state is COLLECT)
//   AddrMode     in   0 = auto-increment pointer, 1 = use DemuxSelect
//   DemuxSelect  in   [2:0] target lane in addressed mode (7 is invalid)
//   Clear        in   synchronous abort; wipes word, mask, pointer, error
//   OutWord      out  [6:0] assembled word, bit i = lane i
//   OutValid     out  OutWord complete and stable
//   OutReady     in   consumer takes OutWord
//   LaneMask     out  [6:0] lanes written in the current word
//   BadSelect    out  sticky: an addressed write used select 7
//------------------------------------------------------------------------------
module demux1to7_collector (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       DataIn,
   input  logic       InValid,
   output logic       InReady,
   input  logic       AddrMode,
   input  logic [2:0] DemuxSelect,
   input  logic       Clear,
   output logic [6:0] OutWord,
   output logic       OutValid,
   input  logic       OutReady,
   output logic [6:0] LaneMask,
   output logic       BadSelect
);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [6:0] word_r;
   logic [6:0] word_s;
   logic [6:0] mask_r;
   logic [6:0] mask_s;
   logic [2:0] ptr_r;
   logic [2:0] ptr_s;
   logic       bad_r;
   logic       bad_s;
   logic       valid_r;
   logic [2:0] lane_s;
   logic       lane_wr_s;

   // Next-state, lane steering and word/mask update
   always_comb begin
      state_s   = state_r;
      word_s    = word_r;
      mask_s    = mask_r;
      ptr_s     = ptr_r;
      bad_s     = bad_r;
      lane_s    = 3'd0;
      lane_wr_s = 1'b0;

      if (Clear) begin
         // Clear outranks both accept and handoff; any offered bit is dropped
         state_s = ST_COLLECT;
         word_s  = 7'h00;
         mask_s  = 7'h00;
         ptr_s   = 3'd0;
         bad_s   = 1'b0;
      end else begin
         case (state_r)
            ST_COLLECT: begin
               if (InValid) begin
                  if (!AddrMode) begin
                     lane_s    = ptr_r;
                     lane_wr_s = 1'b1;
                     ptr_s     = (ptr_r == 3'd6) ? 3'd0 : (ptr_r + 3'd1);
                  end else if (DemuxSelect != 3'd7) begin
                     // Addressed writes leave the auto pointer untouched
                     lane_s    = DemuxSelect;
                     lane_wr_s = 1'b1;
                  end else begin
                     bad_s = 1'b1;
                  end
               end else begin
                  lane_wr_s = 1'b0;
               end

               if (lane_wr_s) begin
                  word_s[lane_s] = DataIn;
                  mask_s[lane_s] = 1'b1;
               end else begin
                  mask_s = mask_r;
               end

               // Completion depends only on which lanes were written
               if (mask_s == 7'h7F) begin
                  state_s = ST_FULL;
               end else begin
                  state_s = ST_COLLECT;
               end
            end

            ST_FULL: begin
               // Word holds; OutWord is left as-is and overwritten by the next word
               if (OutReady) begin
                  state_s = ST_COLLECT;
                  mask_s  = 7'h00;
                  ptr_s   = 3'd0;
               end else begin
                  state_s = ST_FULL;
               end
            end

            default: begin
               state_s = ST_COLLECT;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r <= ST_COLLECT;
         word_r  <= 7'h00;
         mask_r  <= 7'h00;
         ptr_r   <= 3'd0;
         bad_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         word_r  <= word_s;
         mask_r  <= mask_s;
         ptr_r   <= ptr_s;
         bad_r   <= bad_s;
         valid_r <= (state_s == ST_FULL);
      end
   end

   assign InReady   = (state_r == ST_COLLECT);
   assign OutValid  = valid_r;
   assign OutWord   = word_r;
   assign LaneMask  = mask_r;
   assign BadSelect = bad_r;

endmodule

// File: tb/tb_demux1to7_collector.sv
//------------------------------------------------------------------------------
// tb_demux1to7_collector
//
// Table-driven bench: each record holds the inputs for one clock edge and the
// outputs expected just after that edge. Reset behaviour is exercised by
// hand-written sequences because it acts between clock edges.
//------------------------------------------------------------------------------
module tb_demux1to7_collector;

   logic       clk;
   logic       rst_n;
   logic       data_in;
   logic       in_valid;
   logic       in_ready;
   logic       addr_mode;
   logic [2:0] demux_select;
   logic       clear;
   logic [6:0] out_word;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] lane_mask;
   logic       bad_select;

   int errors;
   int checks;

   typedef struct {
      logic       clr;
      logic       iv;
      logic       d;
      logic       am;
      logic [2:0] sel;
      logic       ordy;
      logic [6:0] ew;
      logic [6:0] em;
      logic       eov;
      logic       eir;
      logic       ebad;
   } vec_t;

   vec_t vecs[$];

   demux1to7_collector dut (
      .Clock       (clk),
      .Resetn      (rst_n),
      .DataIn      (data_in),
      .InValid     (in_valid),
      .InReady     (in_ready),
      .AddrMode    (addr_mode),
      .DemuxSelect (demux_select),
      .Clear       (clear),
      .OutWord     (out_word),
      .OutValid    (out_valid),
      .OutReady    (out_ready),
      .LaneMask    (lane_mask),
      .BadSelect   (bad_select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [step %0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [6:0] ew, input logic [6:0] em,
                          input logic eov, input logic eir, input logic ebad);
      chk("OutWord",   idx, out_word,          ew);
      chk("LaneMask",  idx, lane_mask,         em);
      chk("OutValid",  idx, {6'd0, out_valid},  {6'd0, eov});
      chk("InReady",   idx, {6'd0, in_ready},   {6'd0, eir});
      chk("BadSelect", idx, {6'd0, bad_select}, {6'd0, ebad});
   endtask

   task automatic add(input logic clr, input logic iv, input logic d, input logic am,
                      input logic [2:0] sel, input logic ordy, input logic [6:0] ew,
                      input logic [6:0] em, input logic eov, input logic eir, input logic ebad);
      vec_t v;
      v.clr = clr; v.iv = iv; v.d = d; v.am = am; v.sel = sel; v.ordy = ordy;
      v.ew = ew; v.em = em; v.eov = eov; v.eir = eir; v.ebad = ebad;
      vecs.push_back(v);
   endtask

   // Drive on the falling edge, let one rising edge pass, sample 1 time unit later
   task automatic step(input logic clr, input logic iv, input logic d, input logic am,
                       input logic [2:0] sel, input logic ordy);
      @(negedge clk);
      clear = clr; in_valid = iv; data_in = d; addr_mode = am;
      demux_select = sel; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0; data_in = 1'b0; in_valid = 1'b0; addr_mode = 1'b0;
      demux_select = 3'd0; clear = 1'b0; out_ready = 1'b0;

      //   clr   iv    d     am    sel   ordy  word        mask        ov    ir    bad
      // Auto mode word 1,0,1,1,0,0,1 then handoff
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000001, 7'b0000001, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000001, 7'b0000011, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000101, 7'b0000111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0001101, 7'b0001111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0001101, 7'b0011111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0001101, 7'b0111111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b1001101, 7'b1111111, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 7'b1001101, 7'b0000000, 1'b0, 1'b1, 1'b0);
      // Clear, then addressed word with a repeat write to lane 3
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 7'b1000000, 7'b1000000, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 7'b1000001, 7'b1000001, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 7'b1001001, 7'b1001001, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 7'b1001001, 7'b1001011, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 7'b1000001, 7'b1001011, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 7'b1000001, 7'b1001111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 7'b1000001, 7'b1011111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 7'b1001001, 7'b1011111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 7'b1001001, 7'b1111111, 1'b1, 1'b0, 1'b0);
      // FULL with OutReady=0: offered bits ignored in both modes
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b1001001, 7'b1111111, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b1001001, 7'b1111111, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 7'b1001001, 7'b1111111, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 7'b1001001, 7'b1111111, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b1001001, 7'b1111111, 1'b1, 1'b0, 1'b0);
      // Handoff edge drops the offered bit; OutWord kept
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b1001001, 7'b0000000, 1'b0, 1'b1, 1'b0);
      // Bad select, then mixed writes keep BadSelect; OutReady ignored in COLLECT
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 7'b1001001, 7'b0000000, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 7'b1001101, 7'b0000100, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b1001100, 7'b0000101, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b1001110, 7'b0000111, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 7'b1001110, 7'b0000111, 1'b0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b0);
      // Four auto writes, Clear with a bit offered, next write lands in lane 0
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000001, 7'b0000001, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000011, 7'b0000011, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000011, 7'b0000111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0001011, 7'b0001111, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000001, 7'b0000001, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 7'b0000001, 7'b0000011, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0000101, 7'b0000111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0001101, 7'b0001111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0011101, 7'b0011111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b0111101, 7'b0111111, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b1111101, 7'b1111111, 1'b1, 1'b0, 1'b0);
      // Clear in FULL outranks a simultaneous OutReady
      add(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b0);

      // Reset state, checked while reset is held
      #3;
      chk_all(-1, 7'h00, 7'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].am, vecs[i].sel, vecs[i].ordy);
         chk_all(i, vecs[i].ew, vecs[i].em, vecs[i].eov, vecs[i].eir, vecs[i].ebad);
      end

      // Asynchronous reset mid-word (three lanes written) plus a sticky error
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      chk_all(100, 7'b0000111, 7'b0000111, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(101, 7'h00, 7'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill a word of all ones, then reset asynchronously in FULL
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      end
      chk_all(102, 7'h7F, 7'h7F, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(103, 7'h00, 7'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Pointer restarts at lane 0 after reset
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      chk_all(104, 7'b0000001, 7'b0000001, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux1to7_collector.md
Name: demux1to7_collector

Overview:
- Serial-to-parallel demultiplexer/collector: the receive-side counterpart of the 7-to-1 selector.
- Accepts one data bit per handshake and steers it into one of 7 output lanes, either by an internal auto-incrementing lane pointer or by an explicit 3-bit select.
- Presents the assembled 7-bit word with a valid/ready handshake once all 7 lanes have been written.
- Sits between a switch/serial source and downstream display/logic in the lab datapath.

Parameters:
- None. Lane count is fixed at 7 with a 3-bit select; select code 3'b111 is unused.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- DataIn  in  1  serial data bit.
- InValid  in  1  DataIn is valid this cycle.
- InReady  out  1  collector can accept a bit.
- AddrMode  in  1  0 = auto-increment lane pointer; 1 = addressed, using DemuxSelect.
- DemuxSelect  in  3  target lane in addressed mode; 0..6 valid, 7 invalid.
- Clear  in  1  synchronous abort/clear.
- OutWord  out  7  assembled word; bit i = lane i.
- OutValid  out  1  OutWord complete and stable.
- OutReady  in  1  consumer takes OutWord.
- LaneMask  out  7  bit i set once lane i has been written in the current word.
- BadSelect  out  1  sticky error: an addressed write used select 7.

Behaviour:
- Reset (Resetn=0, asynchronous, any state):
  - OutWord=0, LaneMask=0, OutValid=0, BadSelect=0, internal pointer=0, state=COLLECT.
  - InReady=1 during and after reset.
- States: COLLECT, FULL. InReady = (state==COLLECT). OutValid = (state==FULL), registered.
- Accept: rising edge with InValid=1 and InReady=1 (and Clear=0).
  - Auto mode: OutWord[ptr] <= DataIn; LaneMask[ptr] <= 1. ptr increments; after 6 it goes to 0.
  - Addressed mode, DemuxSelect 0..6: OutWord[DemuxSelect] <= DataIn; LaneMask bit set; ptr unchanged.
  - Addressed mode, DemuxSelect=7: no lane written; LaneMask and ptr unchanged; BadSelect <= 1 (sticky).
  - Rewriting an already-written lane overwrites the data; LaneMask is unchanged.
- COLLECT -> FULL: on the edge where the accept makes LaneMask == 7'h7F.
  - OutValid=1 and InReady=0 from the next cycle, so the completed word is visible one cycle after the completing accept.
- FULL:
  - OutWord, LaneMask and ptr hold; InValid is ignored (not accepted).
  - On an edge with OutReady=1: state -> COLLECT, LaneMask <= 0, ptr <= 0, OutValid <= 0.
  - OutWord is not cleared; lanes are overwritten by the next word.
  - No accept is possible on the handoff edge, because InReady was 0.
- OutReady in COLLECT is ignored.
- Mode switch mid-word is legal. Completion is determined solely by LaneMask, not by ptr. Mixed auto/addressed writes may complete a word.
- Clear=1 on an edge, in any state, with priority over accept and handoff:
  - OutWord=0, LaneMask=0, ptr=0, BadSelect=0, state=COLLECT, OutValid=0.
  - A simultaneous InValid bit is dropped.
- Resetn asserted mid-word or in FULL: immediate return to reset values. A partial word is discarded.
- No combinational path from DataIn/InValid to any output. InReady depends only on state.

Test Plan:
1. Reset, auto mode: bits 1,0,1,1,0,0,1 on 7 consecutive cycles with InValid=1 -> OutWord=7'b1001101 with OutValid=1 the cycle after the 7th accept, InReady=0; then OutReady=1 for one cycle -> OutValid=0, InReady=1, LaneMask=0.
2. Addressed mode: write DataIn=1 to lanes 6,0,3, then DataIn=0 to 1,2,4,5 -> OutWord=7'b1001001, OutValid after the 7th distinct lane; a repeat write to lane 3 with 0 before completion -> bit 3 = 0, no early OutValid.
3. Addressed mode, DemuxSelect=7 with InValid=1 -> BadSelect=1, LaneMask unchanged, BadSelect held through later writes; Clear -> BadSelect=0.
4. FULL with OutReady=0 for 5 cycles while InValid=1 and DataIn toggles -> OutWord stable, no lanes altered, InReady=0 throughout.
5. 4 auto writes (LaneMask=7'h0F), then Clear with InValid=1 -> LaneMask=0, OutWord=0, ptr=0, bit dropped; next auto write lands in lane 0.
6. Resetn pulsed low mid-word (LaneMask=7'h07) and in FULL -> all outputs 0 immediately (InReady=1), without waiting for a clock edge.
